// File: rtl/m_axi_burst.sv
// -----------------------------------------------------------------------------
// m_axi_burst
// AXI4 full master that moves one INCR burst of 1..256 beats between a local
// synchronous RAM (one-cycle registered read) and an AXI slave address space.
//   cmd_write=1 : local RAM -> AXI  (AW, then W beats fetched one by one, then B)
//   cmd_write=0 : AXI -> local RAM  (AR, then R beats written straight into RAM)
//
// Ports
//   clk, xrst                 clock, asynchronous active-low reset
//   cmd_start/write/addr/lbase/len   command, accepted only while idle
//   busy, done, err           status (done is a one-cycle pulse, err is sticky)
//   aw*/w*/b*/ar*/r*          AXI4 master channels; side-band fields are
//                             constants (cache=4'b0011, everything else 0)
//   mem_we/addr/wdata/rdata   local RAM port
//
// Build option
//   M_AXI_ERR_CHECK_EN : when defined, err flags a non-OKAY bresp/rresp and
//                        any disagreement between rlast and the programmed
//                        length; a read then also ends after beat len even if
//                        rlast is missing. When undefined err is tied low and
//                        only rlast ends a read.
// -----------------------------------------------------------------------------
module m_axi_burst #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 32,
  parameter int MEMSIZE    = 10,
  parameter int ID_WIDTH   = 1,
  parameter int TXN_ID     = 0,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  xrst,
  // command interface
  input  logic                  cmd_start,
  input  logic                  cmd_write,
  input  logic [AWIDTH-1:0]     cmd_addr,
  input  logic [MEMSIZE-1:0]    cmd_lbase,
  input  logic [7:0]            cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  // AW channel
  output logic [ID_WIDTH-1:0]   awid,
  output logic [AWIDTH-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic [3:0]            awregion,
  output logic [USER_WIDTH-1:0] awuser,
  output logic                  awvalid,
  input  logic                  awready,
  // W channel
  output logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH/8-1:0]   wstrb,
  output logic                  wlast,
  output logic [USER_WIDTH-1:0] wuser,
  output logic                  wvalid,
  input  logic                  wready,
  // B channel
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic [USER_WIDTH-1:0] buser,
  input  logic                  bvalid,
  output logic                  bready,
  // AR channel
  output logic [ID_WIDTH-1:0]   arid,
  output logic [AWIDTH-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic [3:0]            arregion,
  output logic [USER_WIDTH-1:0] aruser,
  output logic                  arvalid,
  input  logic                  arready,
  // R channel
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DWIDTH-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [USER_WIDTH-1:0] ruser,
  input  logic                  rvalid,
  output logic                  rready,
  // local RAM
  output logic                  mem_we,
  output logic [MEMSIZE-1:0]    mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic [DWIDTH-1:0]     mem_rdata
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WADDR  = 4'd1;
  localparam logic [3:0] S_WFETCH = 4'd2;
  localparam logic [3:0] S_WLOAD  = 4'd3;
  localparam logic [3:0] S_WDATA  = 4'd4;
  localparam logic [3:0] S_WRESP  = 4'd5;
  localparam logic [3:0] S_RADDR  = 4'd6;
  localparam logic [3:0] S_RDATA  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [2:0] AXSIZE = 3'($clog2(DWIDTH / 8));

  logic [3:0]         state_reg,    state_next;
  logic [AWIDTH-1:0]  addr_reg,     addr_next;
  logic [MEMSIZE-1:0] lbase_reg,    lbase_next;
  logic [7:0]         len_reg,      len_next;
  logic [7:0]         beat_cnt_reg, beat_cnt_next;
  logic [MEMSIZE-1:0] idx_reg,      idx_next;
  logic [DWIDTH-1:0]  wdata_reg,    wdata_next;

  logic last_beat;
  assign last_beat = (beat_cnt_reg == len_reg);

  // The transfer direction is carried by the state itself (W* vs R* states),
  // so no separate direction register is kept once the command is accepted.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    lbase_next    = lbase_reg;
    len_next      = len_reg;
    beat_cnt_next = beat_cnt_reg;
    idx_next      = idx_reg;
    wdata_next    = wdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_start) begin
          addr_next     = cmd_addr;
          lbase_next    = cmd_lbase;
          len_next      = cmd_len;
          beat_cnt_next = 8'd0;
          idx_next      = '0;
          state_next    = cmd_write ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR:  if (awready) state_next = S_WFETCH;
      S_WFETCH: state_next = S_WLOAD;
      S_WLOAD: begin
        // RAM output belongs to the address presented in WFETCH
        wdata_next = mem_rdata;
        state_next = S_WDATA;
      end
      S_WDATA: begin
        if (wready) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          idx_next      = idx_reg + MEMSIZE'(1);
          state_next    = last_beat ? S_WRESP : S_WFETCH;
        end
      end
      S_WRESP:  if (bvalid) state_next = S_DONE;
      S_RADDR:  if (arready) state_next = S_RDATA;
      S_RDATA: begin
        if (rvalid) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          idx_next      = idx_reg + MEMSIZE'(1);
`ifdef M_AXI_ERR_CHECK_EN
          // A missing rlast must not hang the master: stop after beat len.
          if (rlast || last_beat) state_next = S_DONE;
`else
          if (rlast) state_next = S_DONE;
`endif
        end
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      lbase_reg    <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      lbase_reg    <= lbase_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      idx_reg      <= idx_next;
      wdata_reg    <= wdata_next;
    end
  end

`ifdef M_AXI_ERR_CHECK_EN
  logic err_reg, err_next;

  always_comb begin
    err_next = err_reg;
    if (state_reg == S_IDLE && cmd_start)
      err_next = 1'b0;
    else if (state_reg == S_WRESP && bvalid && bresp != 2'b00)
      err_next = 1'b1;
    // rlast must arrive exactly on beat len, and the response must be OKAY
    else if (state_reg == S_RDATA && rvalid &&
             (rresp != 2'b00 || rlast != last_beat))
      err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  // status
  assign busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done = (state_reg == S_DONE);

  // AW / AR: same burst description on both channels
  assign awid     = ID_WIDTH'(TXN_ID);
  assign awaddr   = addr_reg;
  assign awlen    = len_reg;
  assign awsize   = AXSIZE;
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = 4'b0011;
  assign awprot   = 3'b000;
  assign awqos    = 4'b0000;
  assign awregion = 4'b0000;
  assign awuser   = '0;
  assign awvalid  = (state_reg == S_WADDR);

  assign arid     = ID_WIDTH'(TXN_ID);
  assign araddr   = addr_reg;
  assign arlen    = len_reg;
  assign arsize   = AXSIZE;
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'b0011;
  assign arprot   = 3'b000;
  assign arqos    = 4'b0000;
  assign arregion = 4'b0000;
  assign aruser   = '0;
  assign arvalid  = (state_reg == S_RADDR);

  // W: payload comes from a register, so it stays put while stalled
  assign wdata  = wdata_reg;
  assign wstrb  = {(DWIDTH/8){1'b1}};
  assign wlast  = last_beat;
  assign wuser  = '0;
  assign wvalid = (state_reg == S_WDATA);

  assign bready = (state_reg == S_WRESP);
  assign rready = (state_reg == S_RDATA);

  // Local RAM: fetch address in WFETCH, write-through of R beats in RDATA.
  // The index wraps naturally at MEMSIZE bits.
  always_comb begin
    mem_addr = '0;
    if (state_reg == S_WFETCH || state_reg == S_RDATA)
      mem_addr = lbase_reg + idx_reg;
  end

  assign mem_we    = (state_reg == S_RDATA) && rvalid;
  assign mem_wdata = rdata;

  // IDs and user side-bands from the slave carry no information for this master
  logic unused_inputs;
  assign unused_inputs = ^{bid, rid, ruser, buser, bresp, rresp};

endmodule

// File: tb/tb_m_axi_burst.sv
// -----------------------------------------------------------------------------
// tb_m_axi_burst
// Drives m_axi_burst with directed and $urandom-randomised bursts. The bench
// plays the AXI slave (word memory smem) and the local RAM (lram), and keeps
// its own picture of the local RAM (ref_lram): write bursts must carry
// ref_lram[lbase+b], read bursts must land smem words at lbase+b (mod 1024).
// -----------------------------------------------------------------------------
module tb_m_axi_burst;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MS = 10;
  localparam int WAIT_MAX = 64;
`ifdef M_AXI_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic xrst;
  logic cmd_start, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [MS-1:0] cmd_lbase;
  logic [7:0] cmd_len;
  logic busy, done, err;
  logic [0:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic [0:0] awuser, aruser, wuser, ruser, buser;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic mem_we;
  logic [MS-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] lram     [0:1023];
  logic [DW-1:0] ref_lram [0:1023];
  logic [DW-1:0] smem     [0:4095];
  logic          ram_load;
  logic [MS-1:0] load_addr;
  logic [DW-1:0] load_data;

  int tests = 0;
  int fails = 0;
  int aw_hs = 0;
  int ar_hs = 0;
  int done_cnt = 0;
  int txn = 0;

  m_axi_burst dut (
    .clk(clk), .xrst(xrst),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_lbase(cmd_lbase), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // local RAM with registered read; bench preloads it through a load port
  always @(posedge clk) begin
    if (ram_load) lram[load_addr] <= load_data;
    else if (mem_we) lram[mem_addr] <= mem_wdata;
    mem_rdata <= lram[mem_addr];
  end

  // handshake / pulse counters
  always @(posedge clk) begin
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (arvalid && arready) ar_hs <= ar_hs + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic start_cmd(input bit wr, input logic [AW-1:0] addr,
                           input logic [MS-1:0] lbase, input logic [7:0] len);
    @(negedge clk);
    cmd_start = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_lbase = lbase; cmd_len = len;
    @(negedge clk);
    // scramble the command bus: the DUT must work from its latched copy
    cmd_start = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_lbase = MS'($urandom); cmd_len = 8'($urandom);
    check("busy_after_accept", busy, 1'b1);
    check("err_clear_on_accept", err, 1'b0);
  endtask

  // called on the first cycle of DONE
  task automatic finish_txn(input int aw_exp, input int ar_exp, input int d0, input bit exp_err);
    check("done_pulse", done, 1'b1);
    check("busy_in_done", busy, 1'b0);
    check("err_at_done", err, exp_err);
    check("mem_we_in_done", mem_we, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("err_sticky", err, exp_err);
    check("mem_addr_idle", mem_addr, '0);
    check("aw_handshakes", aw_hs, aw_exp);
    check("ar_handshakes", ar_hs, ar_exp);
    check("done_pulses", done_cnt, d0 + 1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [MS-1:0] lbase,
                          input logic [7:0] len, input int aw_delay, input int stall_max,
                          input logic [1:0] bresp_v, input bit poke, input int rst_beat);
    int aw0, ar0, d0, n;
    logic [DW-1:0] exp_d;
    logic [MS-1:0] la;
    bit exp_err;
    aw0 = aw_hs; ar0 = ar_hs; d0 = done_cnt;
    exp_err = ERR_EN && (bresp_v != 2'b00);
    start_cmd(1'b1, addr, lbase, len);
    n = 0;
    while (!awvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("awvalid", awvalid, 1'b1);
    if (!awvalid) return;
    for (int i = 0; i < aw_delay; i++) begin
      check("aw_held", {awvalid, awaddr, awlen}, {1'b1, addr, len});
      check("no_w_before_aw", wvalid, 1'b0);
      @(negedge clk);
    end
    check("awaddr", awaddr, addr);
    check("awlen", awlen, len);
    check("awsize", awsize, 3'd2);
    check("awburst", awburst, 2'b01);
    check("awid", awid, 1'b0);
    check("awcache", awcache, 4'b0011);
    check("aw_sideband", {awlock, awprot, awqos, awregion, awuser, wuser}, '0);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    if (poke) begin
      // a start pulse while busy must be ignored (would show up as an AR)
      cmd_start = 1'b1; cmd_write = 1'b0;
      @(negedge clk);
      cmd_start = 1'b0;
    end
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!wvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
      check("wvalid", wvalid, 1'b1);
      if (!wvalid) return;
      if (b > 0) check("w_beat_gap", n >= 2, 1'b1);
      la = lbase + MS'(b);
      exp_d = ref_lram[la];
      if (b == rst_beat) begin
        xrst = 1'b0;
        #1;
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wdata", wdata, '0);
        @(negedge clk);
        xrst = 1'b1;
        txn++;
        $display("[TB] txn %0d write reset at beat %0d addr=%08h len=%0d fails=%0d",
                 txn, b, addr, len, fails);
        return;
      end
      repeat ($urandom_range(0, stall_max)) begin
        @(negedge clk);
        check("w_stall_stable", {wvalid, wlast, wdata}, {1'b1, b == int'(len), exp_d});
      end
      check("wdata", wdata, exp_d);
      check("wlast", wlast, b == int'(len));
      check("wstrb", wstrb, 4'hF);
      wready = 1'b1;
      @(negedge clk);
      wready = 1'b0;
      smem[addr[13:2] + 12'(b)] = exp_d;
    end
    n = 0;
    while (!bready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("bready", bready, 1'b1);
    if (!bready) return;
    check("wvalid_low_in_resp", wvalid, 1'b0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("bready_held", bready, 1'b1);
    end
    bvalid = 1'b1; bresp = bresp_v;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    finish_txn(aw0 + 1, ar0, d0, exp_err);
    txn++;
    $display("[TB] txn %0d write addr=%08h lbase=%03h len=%0d bresp=%0d fails=%0d",
             txn, addr, lbase, len, bresp_v, fails);
  endtask

  // rlast_beat: beat index carrying rlast (> len means never)
  // rresp_beat: beat index answered with SLVERR (-1 means none)
  task automatic do_read(input logic [AW-1:0] addr, input logic [MS-1:0] lbase,
                         input logic [7:0] len, input int ar_delay, input int gap_max,
                         input int rlast_beat, input int rresp_beat);
    int aw0, ar0, d0, n, last_b;
    logic [DW-1:0] v;
    logic [MS-1:0] la;
    bit exp_err;
    aw0 = aw_hs; ar0 = ar_hs; d0 = done_cnt;
    last_b = (rlast_beat < int'(len)) ? rlast_beat : int'(len);
    exp_err = ERR_EN && (rlast_beat != int'(len) ||
                         (rresp_beat >= 0 && rresp_beat <= last_b));
    start_cmd(1'b0, addr, lbase, len);
    n = 0;
    while (!arvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("arvalid", arvalid, 1'b1);
    if (!arvalid) return;
    for (int i = 0; i < ar_delay; i++) begin
      check("ar_held", {arvalid, araddr, arlen}, {1'b1, addr, len});
      check("no_rready_before_ar", rready, 1'b0);
      @(negedge clk);
    end
    check("araddr", araddr, addr);
    check("arlen", arlen, len);
    check("arsize", arsize, 3'd2);
    check("arburst", arburst, 2'b01);
    check("arid", arid, 1'b0);
    check("arcache", arcache, 4'b0011);
    check("ar_sideband", {arlock, arprot, arqos, arregion, aruser}, '0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int b = 0; b <= last_b; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        #1;
        check("r_gap_no_we", mem_we, 1'b0);
        check("rready_gap", rready, 1'b1);
        @(negedge clk);
      end
      v = smem[addr[13:2] + 12'(b)];
      la = lbase + MS'(b);
      rvalid = 1'b1; rdata = v; rlast = (b == rlast_beat);
      rresp = (b == rresp_beat) ? 2'b10 : 2'b00;
      #1;
      check("rready", rready, 1'b1);
      check("mem_we", mem_we, 1'b1);
      check("mem_addr", mem_addr, la);
      check("mem_wdata", mem_wdata, v);
      ref_lram[la] = v;
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    end
    finish_txn(aw0, ar0 + 1, d0, exp_err);
    for (int b = 0; b <= last_b; b++) begin
      la = lbase + MS'(b);
      check("lram_contents", lram[la], ref_lram[la]);
    end
    txn++;
    $display("[TB] txn %0d read  addr=%08h lbase=%03h len=%0d beats=%0d fails=%0d",
             txn, addr, lbase, len, last_b + 1, fails);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [MS-1:0] lb;
    logic [7:0] ln;
    xrst = 1'b0;
    cmd_start = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_lbase = '0; cmd_len = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; bid = '0; buser = '0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0; ruser = '0;
    ram_load = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 4096; i++) smem[i] = $urandom;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      ram_load = 1'b1; load_addr = MS'(i);
      load_data = (i == 0) ? 32'hDEADBEEF : $urandom;
      ref_lram[i] = load_data;
    end
    @(negedge clk);
    ram_load = 1'b0;

    // reset state
    check("rst_state_awvalid", awvalid, 1'b0);
    check("rst_state_wvalid", wvalid, 1'b0);
    check("rst_state_arvalid", arvalid, 1'b0);
    check("rst_state_bready", bready, 1'b0);
    check("rst_state_rready", rready, 1'b0);
    check("rst_state_busy", busy, 1'b0);
    check("rst_state_done", done, 1'b0);
    check("rst_state_err", err, 1'b0);
    check("rst_state_mem_we", mem_we, 1'b0);
    check("rst_state_mem_addr", mem_addr, '0);
    check("rst_state_addr_len", {awaddr, awlen, araddr, arlen}, '0);
    check("rst_state_wdata", wdata, '0);
    @(negedge clk);
    xrst = 1'b1;

    // single beat write of local[0]
    do_write(32'h100, 10'h000, 8'd0, 0, 0, 2'b00, 1'b0, -1);
    // 8 beats, late awready, stalled wready
    do_write(32'h200, 10'h040, 8'd7, 5, 2, 2'b00, 1'b0, -1);
    // 16 beats into RAM across the local wrap point, with rvalid gaps
    do_read(32'h100, 10'h3F8, 8'd15, 2, 2, 15, -1);
    // start pulse while busy
    do_write(32'h400, 10'h100, 8'd3, 1, 1, 2'b00, 1'b1, -1);
    // SLVERR on B, then a clean read that must clear err
    do_write(32'h500, 10'h120, 8'd2, 0, 1, 2'b10, 1'b0, -1);
    do_read(32'h500, 10'h200, 8'd2, 0, 1, 2, -1);
    // early rlast on beat 2 of 4
    do_read(32'h600, 10'h210, 8'd3, 0, 1, 1, -1);
`ifdef M_AXI_ERR_CHECK_EN
    // rlast missing, and an SLVERR beat
    do_read(32'h700, 10'h220, 8'd3, 0, 1, 255, -1);
    do_read(32'h740, 10'h230, 8'd3, 0, 1, 3, 2);
`endif
    // reset during beat 3, then a normal write and its read-back
    do_write(32'h800, 10'h300, 8'd5, 0, 1, 2'b00, 1'b0, 2);
    do_write(32'h900, 10'h308, 8'd4, 1, 2, 2'b00, 1'b0, -1);
    do_read(32'h900, 10'h010, 8'd4, 1, 2, 4, -1);

    // randomised mix
    for (int t = 0; t < 24; t++) begin
      a  = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      lb = MS'($urandom);
      ln = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write(a, lb, ln, $urandom_range(0, 3), 2, 2'b00, 1'b0, -1);
      else
        do_read(a, lb, ln, $urandom_range(0, 3), 2, int'(ln), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // absolute time limit so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
